// File: rtl/mealy_pattern_detector.sv
// Serial pattern detector: matches a runtime-loadable PAT_W-bit pattern, MSB first,
// on a valid-qualified bit stream with a same-cycle Mealy strobe and a saturating match counter.
module mealy_pattern_detector #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             sin_valid,
  input  logic             sin,
  output logic             done,
  output logic             done_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat;
  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  window;

  // Candidate pattern window: stored history with the incoming bit appended as LSB.
  assign window = {hist, sin};

  assign done = rst_n & sin_valid & ~clr & ~cfg_load
              & (fill == FILL_MAX) & (window == pat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat       <= PATTERN;
      hist      <= '0;
      fill      <= '0;
      done_q    <= 1'b0;
      match_cnt <= '0;
    end else begin
      done_q <= done;
      if (clr) begin
        hist      <= '0;
        fill      <= '0;
        match_cnt <= '0;
      end else if (cfg_load) begin
        pat  <= cfg_pattern;
        hist <= '0;
        fill <= '0;
      end else if (sin_valid) begin
        // Non-overlapping mode restarts from scratch so the next match needs PAT_W fresh bits.
        if (done && !OVERLAP) begin
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= window[PAT_W-2:0];
          if (fill != FILL_MAX) begin
            fill <= fill + 1'b1;
          end
        end
        if (done && (match_cnt != {CNT_W{1'b1}})) begin
          match_cnt <= match_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mealy_pattern_detector.sv
// Directed bench: three detector configurations (overlap 101, non-overlap 101,
// 2-bit counter 111) share one input stream; each task checks the relevant instance.
module tb_mealy_pattern_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       cfg_load;
  logic [2:0] cfg_pattern;
  logic       sin_valid;
  logic       sin;

  logic       done_a, done_q_a;
  logic [7:0] cnt_a;
  logic       done_b, done_q_b;
  logic [7:0] cnt_b;
  logic       done_c, done_q_c;
  logic [1:0] cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mealy_pattern_detector #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .sin_valid(sin_valid), .sin(sin), .done(done_a), .done_q(done_q_a), .match_cnt(cnt_a)
  );

  mealy_pattern_detector #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .sin_valid(sin_valid), .sin(sin), .done(done_b), .done_q(done_q_b), .match_cnt(cnt_b)
  );

  mealy_pattern_detector #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .sin_valid(sin_valid), .sin(sin), .done(done_c), .done_q(done_q_c), .match_cnt(cnt_c)
  );

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
  task automatic drive(input logic v, input logic s, input logic c, input logic l);
    @(negedge clk);
    sin_valid = v;
    sin       = s;
    clr       = c;
    cfg_load  = l;
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] stream;
    logic [2:0] exp_done;
    stream   = 3'b101;
    exp_done = 3'b001;
    rst_n = 1'b0;
    clr = 1'b0; cfg_load = 1'b0; cfg_pattern = 3'b000; sin_valid = 1'b1; sin = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done_a); end
    checks++;
    if (done_q_a !== 1'b0) begin errors++; $display("FAIL reset_done_q got %0b want 0", done_q_a); end
    checks++;
    if (cnt_a !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt_a); end
    @(negedge clk);
    rst_n = 1'b1;
    sin_valid = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      drive(1'b1, stream[i], 1'b0, 1'b0);
      checks++;
      if (done_a !== exp_done[i]) begin
        errors++; $display("FAIL reset_seq_done bit%0d got %0b want %0b", 3 - i, done_a, exp_done[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (done_q_a !== 1'b1) begin errors++; $display("FAIL reset_seq_done_q got %0b want 1", done_q_a); end
    checks++;
    if (cnt_a !== 8'd1) begin errors++; $display("FAIL reset_seq_cnt got %0d want 1", cnt_a); end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_overlap();
    logic [6:0] stream;
    logic [6:0] exp_done;
    stream   = 7'b1010101;
    exp_done = 7'b0010101;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      drive(1'b1, stream[i], 1'b0, 1'b0);
      checks++;
      if (done_a !== exp_done[i]) begin
        errors++; $display("FAIL overlap_done bit%0d got %0b want %0b", 7 - i, done_a, exp_done[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt_a !== 8'd3) begin errors++; $display("FAIL overlap_cnt got %0d want 3", cnt_a); end
    $display("test_overlap done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_non_overlap();
    logic [6:0] stream;
    logic [6:0] exp_done;
    stream   = 7'b1010101;
    exp_done = 7'b0010001;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      drive(1'b1, stream[i], 1'b0, 1'b0);
      checks++;
      if (done_b !== exp_done[i]) begin
        errors++; $display("FAIL non_overlap_done bit%0d got %0b want %0b", 7 - i, done_b, exp_done[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt_b !== 8'd2) begin errors++; $display("FAIL non_overlap_cnt got %0d want 2", cnt_b); end
    $display("test_non_overlap done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_cnt [7];
    logic [6:0] exp_done;
    logic [6:0] exp_done_q;
    exp_cnt    = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    exp_done   = 7'b1111100;
    exp_done_q = 7'b1111000;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (done_c !== exp_done[k]) begin
        errors++; $display("FAIL b2b_done bit%0d got %0b want %0b", k + 1, done_c, exp_done[k]);
      end
      checks++;
      if (done_q_c !== exp_done_q[k]) begin
        errors++; $display("FAIL b2b_done_q bit%0d got %0b want %0b", k + 1, done_q_c, exp_done_q[k]);
      end
      checks++;
      if (cnt_c !== exp_cnt[k]) begin
        errors++; $display("FAIL b2b_cnt bit%0d got %0d want %0d", k + 1, cnt_c, exp_cnt[k]);
      end
    end
    // clr wins over a bit that would otherwise match.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (done_c !== 1'b0) begin errors++; $display("FAIL clr_done got %0b want 0", done_c); end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (cnt_c !== 2'd0) begin errors++; $display("FAIL clr_cnt got %0d want 0", cnt_c); end
    checks++;
    if (done_q_c !== 1'b0) begin errors++; $display("FAIL clr_done_q got %0b want 0", done_q_c); end
    checks++;
    if (done_c !== 1'b0) begin errors++; $display("FAIL clr_fill1_done got %0b want 0", done_c); end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (done_c !== 1'b0) begin errors++; $display("FAIL clr_fill2_done got %0b want 0", done_c); end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (done_c !== 1'b1) begin errors++; $display("FAIL clr_fill3_done got %0b want 1", done_c); end
    $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_valid_gaps();
    logic [2:0] stream;
    logic [2:0] exp_done;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (done_a !== 1'b0) begin errors++; $display("FAIL gap_idle%0d_done got %0b want 0", i, done_a); end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (done_a !== 1'b0) begin errors++; $display("FAIL gap_bit2_done got %0b want 0", done_a); end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (done_a !== 1'b1) begin errors++; $display("FAIL gap_bit3_done got %0b want 1", done_a); end
    // Leaves history "10": a following 1 would match the old pattern.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (done_a !== 1'b0) begin errors++; $display("FAIL gap_bit4_done got %0b want 0", done_a); end
    cfg_pattern = 3'b110;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (done_a !== 1'b0) begin errors++; $display("FAIL cfg_done got %0b want 0", done_a); end
    stream   = 3'b110;
    exp_done = 3'b001;
    for (int i = 2; i >= 0; i--) begin
      drive(1'b1, stream[i], 1'b0, 1'b0);
      checks++;
      if (done_a !== exp_done[i]) begin
        errors++; $display("FAIL cfg_seq_done bit%0d got %0b want %0b", 3 - i, done_a, exp_done[i]);
      end
      if (i == 2) begin
        checks++;
        if (cnt_a !== 8'd1) begin errors++; $display("FAIL cfg_keeps_cnt got %0d want 1", cnt_a); end
      end
    end
    $display("test_valid_gaps done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_async_reset();
    logic [2:0] stream;
    logic [2:0] exp_done;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (done_q_a !== 1'b1) begin errors++; $display("FAIL pre_rst_done_q got %0b want 1", done_q_a); end
    checks++;
    if (cnt_a !== 8'd2) begin errors++; $display("FAIL pre_rst_cnt got %0d want 2", cnt_a); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (done_q_a !== 1'b0) begin errors++; $display("FAIL async_rst_done_q got %0b want 0", done_q_a); end
    checks++;
    if (cnt_a !== 8'd0) begin errors++; $display("FAIL async_rst_cnt got %0d want 0", cnt_a); end
    @(negedge clk);
    rst_n = 1'b1;
    stream   = 3'b101;
    exp_done = 3'b001;
    for (int i = 2; i >= 0; i--) begin
      drive(1'b1, stream[i], 1'b0, 1'b0);
      checks++;
      if (done_a !== exp_done[i]) begin
        errors++; $display("FAIL post_rst_done bit%0d got %0b want %0b", 3 - i, done_a, exp_done[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    $display("test_async_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_back_to_back();
    test_valid_gaps();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
